// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the unified RAM's data port: CPU (requester 0) and
// IO master (requester 1), round-robin on ties, ISSUE/RESP sequencing per access.
//
// state | meaning
// IDLE  | no access in flight; arbitrate on incoming requests
// ISSUE | registered RAM strobes/address driven, winner's gnt pulses
// RESP  | RAM read data arriving; capture it and arbitrate for the next access
module mem_port_arbiter #(
    parameter int WIDTH         = 16,
    parameter int RAM_ADDR_BITS = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [RAM_ADDR_BITS-1:0] cpu_adr,
    input  logic [WIDTH-1:0]         cpu_wdata,
    output logic                     cpu_gnt,
    output logic                     cpu_rvalid,
    output logic [WIDTH-1:0]         cpu_rdata,
    input  logic                     io_req,
    input  logic                     io_we,
    input  logic [RAM_ADDR_BITS-1:0] io_adr,
    input  logic [WIDTH-1:0]         io_wdata,
    output logic                     io_gnt,
    output logic                     io_rvalid,
    output logic [WIDTH-1:0]         io_rdata,
    output logic                     mem_en,
    output logic                     mem_memwrite,
    output logic                     mem_memread,
    output logic [RAM_ADDR_BITS-1:0] mem_adr,
    output logic [WIDTH-1:0]         mem_writedata,
    input  logic [WIDTH-1:0]         mem_memdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     last_q, last_d;   // 1 = IO won most recently
    logic                     sel_q, sel_d;     // 1 = IO owns the access in flight
    logic                     we_q, we_d;
    logic                     mem_en_q, mem_en_d;
    logic                     mem_wr_q, mem_wr_d;
    logic                     mem_rd_q, mem_rd_d;
    logic [RAM_ADDR_BITS-1:0] mem_adr_q, mem_adr_d;
    logic [WIDTH-1:0]         mem_wdata_q, mem_wdata_d;
    logic                     cpu_gnt_q, cpu_gnt_d;
    logic                     io_gnt_q, io_gnt_d;
    logic                     cpu_rvalid_q, cpu_rvalid_d;
    logic                     io_rvalid_q, io_rvalid_d;
    logic [WIDTH-1:0]         cpu_rdata_q, cpu_rdata_d;
    logic [WIDTH-1:0]         io_rdata_q, io_rdata_d;
    logic                     pick_io;
    logic                     pick_we;

    // IO wins when alone, or on a tie when the CPU went last.
    assign pick_io = io_req & (~cpu_req | ~last_q);
    assign pick_we = pick_io ? io_we : cpu_we;

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        sel_d        = sel_q;
        we_d         = we_q;
        mem_en_d     = 1'b0;
        mem_wr_d     = 1'b0;
        mem_rd_d     = 1'b0;
        mem_adr_d    = mem_adr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_gnt_d    = 1'b0;
        io_gnt_d     = 1'b0;
        cpu_rvalid_d = 1'b0;
        io_rvalid_d  = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        io_rdata_d   = io_rdata_q;

        case (state_q)
            IDLE, RESP: begin
                if (state_q == RESP && !we_q) begin
                    if (sel_q) begin
                        io_rdata_d  = mem_memdata;
                        io_rvalid_d = 1'b1;
                    end else begin
                        cpu_rdata_d  = mem_memdata;
                        cpu_rvalid_d = 1'b1;
                    end
                end
                if (cpu_req || io_req) begin
                    state_d     = ISSUE;
                    sel_d       = pick_io;
                    last_d      = pick_io;
                    we_d        = pick_we;
                    mem_en_d    = 1'b1;
                    mem_wr_d    = pick_we;
                    mem_rd_d    = ~pick_we;
                    mem_adr_d   = pick_io ? io_adr : cpu_adr;
                    mem_wdata_d = pick_io ? io_wdata : cpu_wdata;
                    cpu_gnt_d   = ~pick_io;
                    io_gnt_d    = pick_io;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE:   state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_q       <= 1'b1;
            sel_q        <= 1'b0;
            we_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_adr_q    <= '0;
            mem_wdata_q  <= '0;
            cpu_gnt_q    <= 1'b0;
            io_gnt_q     <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            io_rvalid_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            io_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            mem_rd_q     <= mem_rd_d;
            mem_adr_q    <= mem_adr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_gnt_q    <= cpu_gnt_d;
            io_gnt_q     <= io_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            io_rvalid_q  <= io_rvalid_d;
            cpu_rdata_q  <= cpu_rdata_d;
            io_rdata_q   <= io_rdata_d;
        end
    end

    assign mem_en        = mem_en_q;
    assign mem_memwrite  = mem_wr_q;
    assign mem_memread   = mem_rd_q;
    assign mem_adr       = mem_adr_q;
    assign mem_writedata = mem_wdata_q;
    assign cpu_gnt       = cpu_gnt_q;
    assign io_gnt        = io_gnt_q;
    assign cpu_rvalid    = cpu_rvalid_q;
    assign io_rvalid     = io_rvalid_q;
    assign cpu_rdata     = cpu_rdata_q;
    assign io_rdata      = io_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RAM whose read data
// appears the cycle after the read edge.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, io_req, io_we;
    logic [15:0] cpu_adr, cpu_wdata, io_adr, io_wdata;
    logic        cpu_gnt, cpu_rvalid, io_gnt, io_rvalid;
    logic [15:0] cpu_rdata, io_rdata;
    logic        mem_en, mem_memwrite, mem_memread;
    logic [15:0] mem_adr, mem_writedata, mem_memdata;

    logic [15:0] ram [0:65535];
    int          n_vec  = 0;
    int          n_miss = 0;
    int          wr_pulses;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(16), .RAM_ADDR_BITS(16)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .io_req(io_req), .io_we(io_we), .io_adr(io_adr), .io_wdata(io_wdata),
        .io_gnt(io_gnt), .io_rvalid(io_rvalid), .io_rdata(io_rdata),
        .mem_en(mem_en), .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_adr(mem_adr), .mem_writedata(mem_writedata), .mem_memdata(mem_memdata)
    );

    always @(posedge clk) begin
        if (mem_en && mem_memwrite) ram[mem_adr] <= mem_writedata;
        if (mem_en && mem_memread)  mem_memdata  <= ram[mem_adr];
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [79:0] all_outs();
        return {9'd0, cpu_gnt, cpu_rvalid, cpu_rdata, io_gnt, io_rvalid, io_rdata,
                mem_en, mem_memwrite, mem_memread, mem_adr, mem_writedata};
    endfunction

    initial begin
        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_adr = 0; cpu_wdata = 0;
        io_req = 0; io_we = 0; io_adr = 0; io_wdata = 0;
        mem_memdata = 16'h0;
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0;
        ram[16'h0005] = 16'hBEEF;
        ram[16'h0001] = 16'h00A1;
        ram[16'h0002] = 16'h00A2;
        ram[16'h0020] = 16'h5555;
        tick(); tick();
        reset = 1'b0;

        // idle after reset
        for (int i = 0; i < 10; i++) begin
            check("idle_outs", all_outs(), 80'd0);
            tick();
        end

        // CPU read 0x0005
        cpu_req = 1; cpu_we = 0; cpu_adr = 16'h0005;
        tick();
        check("rd_gnt", {cpu_gnt, io_gnt, mem_en, mem_memread, mem_memwrite}, 5'b10110);
        check("rd_adr", mem_adr, 16'h0005);
        cpu_req = 0;
        tick();
        check("rd_resp_ctl", {cpu_gnt, mem_en, mem_memread, cpu_rvalid}, 4'b0000);
        tick();
        check("rd_rvalid", {cpu_rvalid, io_rvalid}, 2'b10);
        check("rd_data", cpu_rdata, 16'hBEEF);
        check("rd_io_data_held", io_rdata, 16'h0000);
        tick();
        check("rd_rvalid_pulse", cpu_rvalid, 1'b0);

        // IO write 0x0010 <= 0x1234
        wr_pulses = 0;
        io_req = 1; io_we = 1; io_adr = 16'h0010; io_wdata = 16'h1234;
        tick();
        check("wr_gnt", {io_gnt, cpu_gnt, mem_en, mem_memwrite, mem_memread}, 5'b10110);
        check("wr_adr_data", {mem_adr, mem_writedata}, {16'h0010, 16'h1234});
        if (mem_memwrite) wr_pulses++;
        io_req = 0; io_we = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (mem_memwrite) wr_pulses++;
            check("wr_no_rvalid", {io_rvalid, cpu_rvalid}, 2'b00);
        end
        check("wr_pulse_count", wr_pulses, 1);

        // CPU read-after-write of 0x0010
        cpu_req = 1; cpu_we = 0; cpu_adr = 16'h0010;
        tick();
        check("raw_gnt", cpu_gnt, 1'b1);
        cpu_req = 0;
        tick(); tick();
        check("raw_rvalid", cpu_rvalid, 1'b1);
        check("raw_data", cpu_rdata, 16'h1234);
        tick();

        // reset during RESP of a CPU read
        cpu_req = 1; cpu_adr = 16'h0020;
        tick();
        check("rst_gnt", cpu_gnt, 1'b1);
        cpu_req = 0;
        tick();
        reset = 1'b1;
        tick();
        check("rst_outs", all_outs(), 80'd0);
        reset = 1'b0;
        tick();
        check("rst_no_rvalid", all_outs(), 80'd0);
        tick();

        // both requesters held high: strict alternation from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cpu_req = 1; cpu_we = 0; cpu_adr = 16'h0001;
        io_req = 1; io_we = 0; io_adr = 16'h0002;
        for (int k = 0; k < 16; k++) begin
            tick();
            check("rr_gnt", {cpu_gnt, io_gnt}, {k % 4 == 0, k % 4 == 2});
        end
        cpu_req = 0; io_req = 0;
        tick();
        check("rr_last_rvalid", {cpu_rvalid, io_rvalid, io_rdata}, {2'b01, 16'h00A2});
        check("rr_cpu_data", cpu_rdata, 16'h00A1);
        tick(); tick();

        // back-to-back CPU reads 0x0001, 0x0002
        cpu_req = 1; cpu_adr = 16'h0001;
        tick();
        check("b2b_gnt0", {cpu_gnt, mem_adr}, {1'b1, 16'h0001});
        tick();
        cpu_adr = 16'h0002;
        check("b2b_resp0", cpu_rvalid, 1'b0);
        tick();
        check("b2b_gnt1", {cpu_gnt, mem_adr}, {1'b1, 16'h0002});
        check("b2b_rv0", {cpu_rvalid, cpu_rdata}, {1'b1, 16'h00A1});
        cpu_req = 0;
        tick();
        check("b2b_gap", cpu_rvalid, 1'b0);
        tick();
        check("b2b_rv1", {cpu_rvalid, cpu_rdata}, {1'b1, 16'h00A2});
        tick();
        check("b2b_end", {cpu_rvalid, mem_en}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
